// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 4-digit seven-segment driver. One anode is enabled at a
// time. Each digit slot lasts SCAN_DIV clocks. The first cycle of every slot
// is a guard cycle with all anodes off, which prevents ghosting while the
// segment lines change. Hex values are decoded to segments. The driver also
// applies leading-zero blanking, per-digit blinking and decimal points. All
// pin outputs are registered.
//
// Parameters:
//   SCAN_DIV   - clock cycles per digit slot (>= 2)
//   BLINK_DIV  - clock cycles per blink half-period (>= 1)
//   ACTIVE_LOW - 1: AN/SEG/DP pins are active-low, 0: active-high
//
// Ports:
//   CLK        in   1  system clock
//   RST        in   1  synchronous, active-high reset
//   DIGIT_3..0 in   4  digit values, DIGIT_3 is leftmost
//   DP_EN      in   4  decimal-point enable per digit
//   BLINK_MASK in   4  per-digit blink enable
//   BLANK_LZ   in   1  suppress leading zeros
//   AN         out  4  anode enables, bit i = digit i
//   SEG        out  7  segments {g,f,e,d,c,b,a}
//   DP         out  1  decimal point
//   DIGIT_IDX  out  2  digit slot currently being scanned
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int SCAN_DIV   = 100000,
   parameter int BLINK_DIV  = 25000000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] DIGIT_3,
   input  logic [3:0] DIGIT_2,
   input  logic [3:0] DIGIT_1,
   input  logic [3:0] DIGIT_0,
   input  logic [3:0] DP_EN,
   input  logic [3:0] BLINK_MASK,
   input  logic       BLANK_LZ,
   output logic [3:0] AN,
   output logic [6:0] SEG,
   output logic       DP,
   output logic [1:0] DIGIT_IDX
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   // XOR masks that turn internal active-high levels into pin polarity.
   localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
   localparam logic       DP_POL  = ACTIVE_LOW;

   // Hex to active-high segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] seg;
      case (value)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
   logic [1:0]         digit_idx_q,   digit_idx_d;
   logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic               blink_phase_q, blink_phase_d;
   logic [3:0]         an_q,          an_d;
   logic [6:0]         seg_q,         seg_d;
   logic               dp_q,          dp_d;

   logic       scan_wrap;
   logic       blink_wrap;
   logic       guard;
   logic [3:0] cur_digit;
   logic       lz_blank;
   logic       slot_blank;
   logic [3:0] an_act;
   logic [6:0] seg_act;
   logic       dp_act;

   // NOTE: every signal is given a default before any branch. This means no
   // path can leave a value unassigned, so no latch is inferred.
   always_comb begin
      scan_wrap   = (scan_cnt_q == SCAN_LAST);
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

      // The blink timebase runs freely. It does not depend on the scan.
      blink_wrap    = (blink_cnt_q == BLINK_LAST);
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q ^ blink_wrap;

      guard     = (scan_cnt_q == '0);
      cur_digit = DIGIT_0;
      lz_blank  = 1'b0;
      case (digit_idx_q)
         2'd3: begin
            cur_digit = DIGIT_3;
            lz_blank  = (DIGIT_3 == 4'd0);
         end
         2'd2: begin
            cur_digit = DIGIT_2;
            lz_blank  = (DIGIT_3 == 4'd0) && (DIGIT_2 == 4'd0);
         end
         2'd1: begin
            cur_digit = DIGIT_1;
            lz_blank  = (DIGIT_3 == 4'd0) && (DIGIT_2 == 4'd0) && (DIGIT_1 == 4'd0);
         end
         default: begin
            // The rightmost digit always shows, so an all-zero value reads "0".
            cur_digit = DIGIT_0;
            lz_blank  = 1'b0;
         end
      endcase

      slot_blank = (BLANK_LZ && lz_blank) || (blink_phase_q && BLINK_MASK[digit_idx_q]);

      // A blanked slot keeps its full length in the scan. It only stays dark.
      an_act  = (slot_blank || guard) ? 4'b0000 : (4'b0001 << digit_idx_q);
      seg_act = slot_blank ? 7'h00 : hex_to_seg(cur_digit);
      dp_act  = !slot_blank && DP_EN[digit_idx_q];

      an_d  = an_act  ^ AN_POL;
      seg_d = seg_act ^ SEG_POL;
      dp_d  = dp_act  ^ DP_POL;
   end

   // NOTE: state registers use non-blocking assignments only. As a result,
   // every flop samples pre-edge values, whatever order the statements are in.
   always_ff @(posedge CLK) begin
      if (RST) begin
         scan_cnt_q    <= '0;
         digit_idx_q   <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an_q          <= AN_POL;
         seg_q         <= SEG_POL;
         dp_q          <= DP_POL;
      end else begin
         scan_cnt_q    <= scan_cnt_d;
         digit_idx_q   <= digit_idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign AN        = an_q;
   assign SEG       = seg_q;
   assign DP        = dp_q;
   assign DIGIT_IDX = digit_idx_q;

endmodule
